// File: rtl/fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl
// Sequencer between the FP decode/issue stage and the FPU datapath. Accepts
// one operation over a valid/ready request port, holds the datapath start
// high until done, captures the result and flags, returns them over a
// valid/ready response port and maintains the sticky fflags register.
//
// Optional build macro: FPU_ISSUE_WDOG_EN
//   Adds an EXEC/DRAIN cycle watchdog. On expiry the op completes with a
//   canonical qNaN and the invalid flag, and wdog_err pulses for one cycle.
//
// Ports:
//   clk, reset        clock and synchronous active-low reset
//   req_*             request handshake and operation fields
//   csr_frm           dynamic rounding mode captured with the request
//   flush             kill the in-flight operation
//   fpu_*  (out)      datapath start, op, rounding modes and operands
//   fpu_out/done/flags datapath result interface
//   resp_*            response handshake, data, tag and flags
//   fflags, fflags_we, fflags_wdata  sticky accrued flags and CSR write path
//   busy, wdog_err    status
// -----------------------------------------------------------------------------
module fpu_issue_ctrl #(
    parameter int TAG_W       = 5,
    parameter int WDOG_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [2:0]       req_rm,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             req_rs2_lsb,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [2:0]       csr_frm,
    input  logic             flush,
    output logic             fpu_start,
    output logic [4:0]       fpu_op,
    output logic [2:0]       fpu_rm,
    output logic [2:0]       fpu_csr_rm,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic             fpu_rs2_lsb,
    input  logic [31:0]      fpu_out,
    input  logic             fpu_done,
    input  logic [4:0]       fpu_flags,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic [4:0]       resp_flags,
    output logic [4:0]       fflags,
    input  logic             fflags_we,
    input  logic [4:0]       fflags_wdata,
    output logic             busy,
    output logic             wdog_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               accept_s, capture_s, accrue_s, done_eff_s, wdog_fire_s;
    logic [4:0]         op_q, op_d;
    logic [2:0]         rm_q, rm_d, csr_rm_q, csr_rm_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               rs2_q, rs2_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        data_q, data_d;
    logic [4:0]         flags_q, flags_d, fflags_q, fflags_d;
    logic               start_q, start_d, rvalid_q, rvalid_d;
    logic               rready_q, rready_d, busy_q, busy_d;

    // A watchdog expiry is treated exactly like a datapath done.
    assign done_eff_s = fpu_done | wdog_fire_s;

    // FSM next state and the accept/capture/accrue decisions
    always_comb begin
        state_d   = state_q;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        accrue_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A flush coinciding with a request suppresses the acceptance.
                if (req_valid && !flush) begin
                    state_d  = S_EXEC;
                    accept_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (done_eff_s) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_RESP;
                        capture_s = 1'b1;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_DRAIN: begin
                if (done_eff_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_RESP: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (resp_ready) begin
                    state_d  = S_IDLE;
                    accrue_s = 1'b1;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values for the holding registers, registered outputs and fflags
    always_comb begin
        op_d     = op_q;
        rm_d     = rm_q;
        csr_rm_d = csr_rm_q;
        a_d      = a_q;
        b_d      = b_q;
        rs2_d    = rs2_q;
        tag_d    = tag_q;
        data_d   = data_q;
        flags_d  = flags_q;
        if (accept_s) begin
            op_d     = req_op;
            rm_d     = req_rm;
            csr_rm_d = csr_frm;
            a_d      = req_a;
            b_d      = req_b;
            rs2_d    = req_rs2_lsb;
            tag_d    = req_tag;
        end else begin
            op_d = op_q;
        end
        if (capture_s) begin
            // A real done in the expiry cycle takes precedence over the watchdog.
            if (wdog_fire_s) begin
                data_d  = 32'h7FC0_0000;
                flags_d = 5'b10000;
            end else begin
                data_d  = fpu_out;
                flags_d = fpu_flags;
            end
        end else begin
            data_d = data_q;
        end
        // A CSR write overrides the old value but still merges a same-cycle accrual.
        if (fflags_we) begin
            fflags_d = fflags_wdata | (accrue_s ? flags_q : 5'b00000);
        end else if (accrue_s) begin
            fflags_d = fflags_q | flags_q;
        end else begin
            fflags_d = fflags_q;
        end
        start_d  = (state_d == S_EXEC) || (state_d == S_DRAIN);
        rvalid_d = (state_d == S_RESP);
        rready_d = (state_d == S_IDLE);
        busy_d   = (state_d != S_IDLE);
    end

    // State, holding and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= 5'd0;
            rm_q     <= 3'd0;
            csr_rm_q <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            rs2_q    <= 1'b0;
            tag_q    <= '0;
            data_q   <= 32'd0;
            flags_q  <= 5'd0;
            fflags_q <= 5'd0;
            start_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rready_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rm_q     <= rm_d;
            csr_rm_q <= csr_rm_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rs2_q    <= rs2_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            flags_q  <= flags_d;
            fflags_q <= fflags_d;
            start_q  <= start_d;
            rvalid_q <= rvalid_d;
            rready_q <= rready_d;
            busy_q   <= busy_d;
        end
    end

`ifdef FPU_ISSUE_WDOG_EN
    logic [7:0] wdog_cnt_q, wdog_cnt_d;
    logic       wdog_err_q;

    assign wdog_fire_s = ((state_q == S_EXEC) || (state_q == S_DRAIN)) &&
                         (wdog_cnt_q == 8'(WDOG_CYCLES - 1)) && !fpu_done;

    // Counter restarts on every entry into EXEC or DRAIN
    always_comb begin
        if (((state_q == S_EXEC) || (state_q == S_DRAIN)) && (state_d == state_q)) begin
            wdog_cnt_d = wdog_cnt_q + 8'd1;
        end else begin
            wdog_cnt_d = 8'd0;
        end
    end

    // Watchdog counter and error pulse registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog_cnt_q <= 8'd0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_fire_s;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    logic unused_wdog_s;
    assign wdog_fire_s   = 1'b0;
    assign unused_wdog_s = (WDOG_CYCLES == 0);
    assign wdog_err      = 1'b0;
`endif

    assign req_ready   = rready_q;
    assign fpu_start   = start_q;
    assign fpu_op      = op_q;
    assign fpu_rm      = rm_q;
    assign fpu_csr_rm  = csr_rm_q;
    assign fpu_a       = a_q;
    assign fpu_b       = b_q;
    assign fpu_rs2_lsb = rs2_q;
    assign resp_valid  = rvalid_q;
    assign resp_data   = data_q;
    assign resp_tag    = tag_q;
    assign resp_flags  = flags_q;
    assign fflags      = fflags_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, req_rs2_lsb, flush;
    logic [4:0]  req_op, req_tag, fpu_op, resp_tag, fpu_flags, resp_flags;
    logic [4:0]  fflags, fflags_wdata;
    logic [2:0]  req_rm, csr_frm, fpu_rm, fpu_csr_rm;
    logic [31:0] req_a, req_b, fpu_a, fpu_b, fpu_out, resp_data;
    logic        fpu_start, fpu_rs2_lsb, fpu_done, resp_valid, resp_ready;
    logic        fflags_we, busy, wdog_err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [4:0]  exp_fflags;

    fpu_issue_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rm(req_rm), .req_a(req_a), .req_b(req_b),
        .req_rs2_lsb(req_rs2_lsb), .req_tag(req_tag), .csr_frm(csr_frm), .flush(flush),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_csr_rm(fpu_csr_rm),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_rs2_lsb(fpu_rs2_lsb), .fpu_out(fpu_out),
        .fpu_done(fpu_done), .fpu_flags(fpu_flags), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
        .resp_flags(resp_flags), .fflags(fflags), .fflags_we(fflags_we),
        .fflags_wdata(fflags_wdata), .busy(busy), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        vectors++;
        if (req_ready !== 1'b1 || fpu_start !== 1'b0 || resp_valid !== 1'b0 ||
            fflags !== 5'd0 || busy !== 1'b0 || resp_data !== 32'd0 || wdog_err !== 1'b0) begin
            $display("FAIL reset_state: ready=%b start=%b rvalid=%b fflags=%b busy=%b data=%h expected 1 0 0 00000 0 0",
                     req_ready, fpu_start, resp_valid, fflags, busy, resp_data);
            miscompares++;
        end
        reset = 1'b1;
        exp_fflags = 5'd0;
    endtask

    task automatic test_fadd();
        req_rm = 3'b000; csr_frm = 3'b010; req_rs2_lsb = 1'b1; resp_ready = 1'b1;
        issue(5'b00000, 32'h3F80_0000, 32'h4000_0000, 5'h0A);
        vectors++;
        if (fpu_start !== 1'b1 || req_ready !== 1'b0 || fpu_op !== 5'b00000 ||
            fpu_a !== 32'h3F80_0000 || fpu_b !== 32'h4000_0000 || fpu_rm !== 3'b000 ||
            fpu_csr_rm !== 3'b010 || fpu_rs2_lsb !== 1'b1) begin
            $display("FAIL fadd_exec: start=%b ready=%b op=%b a=%h b=%h csr_rm=%b expected 1 0 00000 3f800000 40000000 010",
                     fpu_start, req_ready, fpu_op, fpu_a, fpu_b, fpu_csr_rm);
            miscompares++;
        end
        fpu_done = 1'b1; fpu_out = 32'h4040_0000; fpu_flags = 5'd0;
        tick();
        fpu_done = 1'b0;
        vectors++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h4040_0000 || resp_tag !== 5'h0A ||
            fpu_start !== 1'b0 || fflags !== 5'd0) begin
            $display("FAIL fadd_resp: rvalid=%b data=%h tag=%h start=%b fflags=%b expected 1 40400000 0a 0 00000",
                     resp_valid, resp_data, resp_tag, fpu_start, fflags);
            miscompares++;
        end
        tick();
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || fflags !== exp_fflags) begin
            $display("FAIL fadd_done: rvalid=%b ready=%b fflags=%b expected 0 1 %b",
                     resp_valid, req_ready, fflags, exp_fflags);
            miscompares++;
        end
    endtask

    task automatic test_fdiv();
        resp_ready = 1'b1;
        issue(5'b00011, 32'h3F80_0000, 32'h0000_0000, 5'h11);
        for (int c = 1; c <= 10; c++) begin
            vectors++;
            if (fpu_start !== 1'b1 || resp_valid !== 1'b0) begin
                $display("FAIL fdiv_start_c%0d: start=%b rvalid=%b expected 1 0", c, fpu_start, resp_valid);
                miscompares++;
            end
            if (c == 10) begin
                fpu_done = 1'b1; fpu_out = 32'h7F80_0000; fpu_flags = 5'b01000;
            end
            tick();
        end
        fpu_done = 1'b0;
        vectors++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h7F80_0000 || resp_flags !== 5'b01000 || resp_tag !== 5'h11) begin
            $display("FAIL fdiv_resp: rvalid=%b data=%h flags=%b tag=%h expected 1 7f800000 01000 11",
                     resp_valid, resp_data, resp_flags, resp_tag);
            miscompares++;
        end
        tick();
        exp_fflags = exp_fflags | 5'b01000;
        vectors++;
        if (fflags !== exp_fflags) begin
            $display("FAIL fdiv_fflags: got %b expected %b", fflags, exp_fflags);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        issue(5'b00010, 32'h1234_5678, 32'h9ABC_DEF0, 5'h1C);
        tick();
        fpu_done = 1'b1; fpu_out = 32'hCAFE_F00D; fpu_flags = 5'b00001;
        tick();
        fpu_done = 1'b0; fpu_out = 32'h0; fpu_flags = 5'd0;
        req_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            vectors++;
            if (resp_valid !== 1'b1 || resp_data !== 32'hCAFE_F00D || resp_tag !== 5'h1C ||
                resp_flags !== 5'b00001 || req_ready !== 1'b0 || fflags !== exp_fflags) begin
                $display("FAIL bp_hold_%0d: rvalid=%b data=%h tag=%h flags=%b ready=%b fflags=%b expected 1 cafef00d 1c 00001 0 %b",
                         j, resp_valid, resp_data, resp_tag, resp_flags, req_ready, fflags, exp_fflags);
                miscompares++;
            end
            tick();
        end
        // req_valid stays high across the handshake: it must not be taken yet
        resp_ready = 1'b1;
        tick();
        exp_fflags = exp_fflags | 5'b00001;
        vectors++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || fflags !== exp_fflags) begin
            $display("FAIL bp_handshake: busy=%b ready=%b rvalid=%b fflags=%b expected 0 1 0 %b",
                     busy, req_ready, resp_valid, fflags, exp_fflags);
            miscompares++;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_flush_drain();
        resp_ready = 1'b1;
        issue(5'b00011, 32'h4000_0000, 32'h0000_0000, 5'h03);
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (fpu_start !== 1'b1 || busy !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
                $display("FAIL drain_hold_%0d: start=%b busy=%b rvalid=%b ready=%b expected 1 1 0 0",
                         c, fpu_start, busy, resp_valid, req_ready);
                miscompares++;
            end
            if (c == 4) begin
                fpu_done = 1'b1; fpu_flags = 5'b01000; fpu_out = 32'h7F80_0000;
            end
            tick();
        end
        fpu_done = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || fpu_start !== 1'b0 || resp_valid !== 1'b0 || fflags !== exp_fflags) begin
            $display("FAIL drain_done: ready=%b start=%b rvalid=%b fflags=%b expected 1 0 0 %b",
                     req_ready, fpu_start, resp_valid, fflags, exp_fflags);
            miscompares++;
        end
    endtask

    task automatic test_csr_collision();
        resp_ready = 1'b0;
        issue(5'b00001, 32'hFF80_0000, 32'h7F80_0000, 5'h07);
        fpu_done = 1'b1; fpu_out = 32'h7FC0_0000; fpu_flags = 5'b10000;
        tick();
        fpu_done = 1'b0;
        resp_ready = 1'b1; fflags_we = 1'b1; fflags_wdata = 5'b00001;
        tick();
        fflags_we = 1'b0;
        exp_fflags = 5'b10001;
        vectors++;
        if (fflags !== exp_fflags) begin
            $display("FAIL csr_collision: got %b expected %b", fflags, exp_fflags);
            miscompares++;
        end
        fflags_we = 1'b1; fflags_wdata = 5'b00100;
        tick();
        fflags_we = 1'b0;
        exp_fflags = 5'b00100;
        vectors++;
        if (fflags !== exp_fflags) begin
            $display("FAIL csr_write: got %b expected %b", fflags, exp_fflags);
            miscompares++;
        end
    endtask

    task automatic test_reset_exec();
        issue(5'b00100, 32'h4080_0000, 32'h0, 5'h15);
        tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_fflags = 5'd0;
        vectors++;
        if (fpu_start !== 1'b0 || resp_valid !== 1'b0 || fflags !== 5'd0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_exec: start=%b rvalid=%b fflags=%b ready=%b busy=%b expected 0 0 00000 1 0",
                     fpu_start, resp_valid, fflags, req_ready, busy);
            miscompares++;
        end
    endtask

    task automatic test_watchdog();
        resp_ready = 1'b0;
        issue(5'b00100, 32'h4080_0000, 32'h0, 5'h09);
`ifdef FPU_ISSUE_WDOG_EN
        for (int c = 1; c <= 63; c++) tick();
        vectors++;
        if (fpu_start !== 1'b1 || wdog_err !== 1'b0 || resp_valid !== 1'b0) begin
            $display("FAIL wdog_pre: start=%b wdog=%b rvalid=%b expected 1 0 0", fpu_start, wdog_err, resp_valid);
            miscompares++;
        end
        tick();
        vectors++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h7FC0_0000 || resp_flags !== 5'b10000 ||
            wdog_err !== 1'b1 || fpu_start !== 1'b0) begin
            $display("FAIL wdog_fire: rvalid=%b data=%h flags=%b wdog=%b start=%b expected 1 7fc00000 10000 1 0",
                     resp_valid, resp_data, resp_flags, wdog_err, fpu_start);
            miscompares++;
        end
        resp_ready = 1'b1;
        tick();
        exp_fflags = exp_fflags | 5'b10000;
        vectors++;
        if (wdog_err !== 1'b0 || fflags !== exp_fflags) begin
            $display("FAIL wdog_after: wdog=%b fflags=%b expected 0 %b", wdog_err, fflags, exp_fflags);
            miscompares++;
        end
`else
        for (int c = 0; c < 80; c++) begin
            vectors++;
            if (fpu_start !== 1'b1 || resp_valid !== 1'b0 || wdog_err !== 1'b0) begin
                $display("FAIL nowdog_wait_%0d: start=%b rvalid=%b wdog=%b expected 1 0 0",
                         c, fpu_start, resp_valid, wdog_err);
                miscompares++;
            end
            tick();
        end
        fpu_done = 1'b1; fpu_out = 32'h4110_0000; fpu_flags = 5'b00000;
        tick();
        fpu_done = 1'b0; resp_ready = 1'b1;
        vectors++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h4110_0000) begin
            $display("FAIL nowdog_resp: rvalid=%b data=%h expected 1 41100000", resp_valid, resp_data);
            miscompares++;
        end
        tick();
`endif
        resp_ready = 1'b0;
    endtask

    // Random ops: the model predicts each op's fate from its latency, flush
    // point, backpressure and CSR write, then checks the outcome.
    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int unsigned lat, mode, bp, kf;
            logic [4:0]  op, tag, fl, wd;
            logic [31:0] a, b, res;
            logic [2:0]  rm, frm;
            logic        rs2, we;
            lat = $urandom_range(1, 6); mode = $urandom_range(0, 4); bp = $urandom_range(0, 3);
            op = 5'($urandom); tag = 5'($urandom); a = $urandom; b = $urandom; res = $urandom;
            rm = 3'($urandom); frm = 3'($urandom); rs2 = 1'($urandom); fl = 5'($urandom);
            we = ($urandom_range(0, 3) == 0); wd = 5'($urandom);
            if (mode == 1 && lat < 2) lat = 2;
            kf = (mode == 1) ? $urandom_range(1, lat - 1) : 0;
            resp_ready = 1'b0;
            if (mode == 4) begin
                req_valid = 1'b1; flush = 1'b1;
                tick();
                req_valid = 1'b0; flush = 1'b0;
                vectors++;
                if (busy !== 1'b0 || req_ready !== 1'b1) begin
                    $display("FAIL rnd%0d_flush_accept: busy=%b ready=%b expected 0 1", n, busy, req_ready);
                    miscompares++;
                end
            end
            req_rm = rm; csr_frm = frm; req_rs2_lsb = rs2;
            issue(op, a, b, tag);
            vectors++;
            if (fpu_op !== op || fpu_a !== a || fpu_b !== b || fpu_rm !== rm ||
                fpu_csr_rm !== frm || fpu_rs2_lsb !== rs2 || fpu_start !== 1'b1) begin
                $display("FAIL rnd%0d_latch: op=%b a=%h b=%h rm=%b frm=%b start=%b expected %b %h %h %b %b 1",
                         n, fpu_op, fpu_a, fpu_b, fpu_rm, fpu_csr_rm, fpu_start, op, a, b, rm, frm);
                miscompares++;
            end
            for (int unsigned c = 1; c <= lat; c++) begin
                if (c == lat) begin
                    fpu_done = 1'b1; fpu_out = res; fpu_flags = fl;
                end
                if ((mode == 1 && c == kf) || (mode == 2 && c == lat)) flush = 1'b1;
                tick();
                fpu_done = 1'b0; flush = 1'b0;
                if (c < lat) begin
                    vectors++;
                    if (fpu_start !== 1'b1 || busy !== 1'b1 || resp_valid !== 1'b0) begin
                        $display("FAIL rnd%0d_exec_c%0d: start=%b busy=%b rvalid=%b expected 1 1 0",
                                 n, c, fpu_start, busy, resp_valid);
                        miscompares++;
                    end
                end
            end
            if (mode == 1 || mode == 2) begin
                vectors++;
                if (busy !== 1'b0 || resp_valid !== 1'b0 || fflags !== exp_fflags) begin
                    $display("FAIL rnd%0d_killed: busy=%b rvalid=%b fflags=%b expected 0 0 %b",
                             n, busy, resp_valid, fflags, exp_fflags);
                    miscompares++;
                end
            end else begin
                for (int unsigned j = 0; j <= bp; j++) begin
                    vectors++;
                    if (resp_valid !== 1'b1 || resp_data !== res || resp_tag !== tag ||
                        resp_flags !== fl || fflags !== exp_fflags || fpu_start !== 1'b0) begin
                        $display("FAIL rnd%0d_resp_%0d: rvalid=%b data=%h tag=%h flags=%b fflags=%b expected 1 %h %h %b %b",
                                 n, j, resp_valid, resp_data, resp_tag, resp_flags, fflags, res, tag, fl, exp_fflags);
                        miscompares++;
                    end
                    if (j == bp) begin
                        resp_ready = 1'b1; flush = (mode == 3); fflags_we = we; fflags_wdata = wd;
                    end
                    tick();
                end
                resp_ready = 1'b0; flush = 1'b0; fflags_we = 1'b0;
                if (mode == 3) exp_fflags = we ? wd : exp_fflags;
                else           exp_fflags = we ? (wd | fl) : (exp_fflags | fl);
                vectors++;
                if (busy !== 1'b0 || resp_valid !== 1'b0 || fflags !== exp_fflags) begin
                    $display("FAIL rnd%0d_end: busy=%b rvalid=%b fflags=%b expected 0 0 %b",
                             n, busy, resp_valid, fflags, exp_fflags);
                    miscompares++;
                end
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_op = 5'd0; req_rm = 3'd0; req_a = 32'd0;
        req_b = 32'd0; req_rs2_lsb = 1'b0; req_tag = 5'd0; csr_frm = 3'd0; flush = 1'b0;
        fpu_out = 32'd0; fpu_done = 1'b0; fpu_flags = 5'd0; resp_ready = 1'b0;
        fflags_we = 1'b0; fflags_wdata = 5'd0; exp_fflags = 5'd0;
        test_reset();
        test_fadd();
        test_fdiv();
        test_backpressure();
        test_flush_drain();
        test_csr_collision();
        test_reset_exec();
        test_watchdog();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
